// File: rtl/dec3x8_seq.sv
//-----------------------------------------------------------------------------
// dec3x8_seq
//
// Sequenced 3-to-8 decoder. An accepted 3-bit code is turned into a registered
// one-hot word that stays asserted for HOLD clock cycles. It is followed by a
// single idle "gap" cycle before the next code can be accepted.
//
// Parameters
//   HOLD       number of cycles each one-hot output stays asserted (1..16)
//
// Ports
//   clk        single clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   en         acceptance enable (only gates acceptance in IDLE)
//   in_valid   code is valid this cycle
//   code       binary index to decode
//   in_ready   block can accept a code this cycle (combinational)
//   y          registered one-hot decode, zero outside the hold window
//   y_valid    high exactly while y is non-zero
//   last_code  most recently accepted code
//   acc_cnt    count of accepted codes, wraps 255 -> 0
//-----------------------------------------------------------------------------
module dec3x8_seq #(
   parameter int HOLD = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       in_valid,
   input  logic [2:0] code,
   output logic       in_ready,
   output logic [7:0] y,
   output logic       y_valid,
   output logic [2:0] last_code,
   output logic [7:0] acc_cnt
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_HOLD = 2'd1;
   localparam logic [1:0] ST_GAP  = 2'd2;

   // Counter is loaded with HOLD-1 on acceptance; the edge on which it reads 0
   // is the one that drops y, giving exactly HOLD asserted cycles.
   localparam logic [3:0] HOLD_LOAD = 4'(HOLD - 1);

   logic [1:0] state;
   logic [3:0] hold_cnt;
   logic       handshake;

   function automatic logic [7:0] onehot(input logic [2:0] c);
      onehot = 8'b0000_0001 << c;
   endfunction

   assign in_ready  = (state == ST_IDLE) && en;
   assign handshake = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         hold_cnt  <= 4'd0;
         y         <= 8'd0;
         y_valid   <= 1'b0;
         last_code <= 3'd0;
         acc_cnt   <= 8'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (handshake) begin
                  y         <= onehot(code);
                  y_valid   <= 1'b1;
                  last_code <= code;
                  acc_cnt   <= acc_cnt + 8'd1;
                  hold_cnt  <= HOLD_LOAD;
                  state     <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               // Inputs are deliberately not looked at here: nothing is queued
               // and en cannot cut the pulse short.
               if (hold_cnt == 4'd0) begin
                  y       <= 8'd0;
                  y_valid <= 1'b0;
                  state   <= ST_GAP;
               end else begin
                  hold_cnt <= hold_cnt - 4'd1;
               end
            end
            ST_GAP: begin
               state <= ST_IDLE;
            end
            default: begin
               state   <= ST_IDLE;
               y       <= 8'd0;
               y_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
